seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display.sv | 128 ++++++++++++
 tb/tb_seg_scan_display.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment driver.
// Holds a small digit buffer written one entry per cycle, scans the digits in
// fixed time slots with an anode-off dead time at the start of every slot, and
// optionally blinks selected digits from a free-running blink timer. Anode and
// segment outputs are registered and active-low.
module seg_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic [7:0] blink_mask,
  output logic [7:0] seg_an,
  output logic [7:0] seg_out
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  BLANK_END  = SCAN_W'(BLANK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Buffer entry layout: {blank, dp, value[3:0]}; reset value is a dark digit.
  localparam logic [5:0] ENTRY_DARK = 6'b10_0000;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [5:0]         dbuf [8];

  logic [5:0]         ent;
  logic [7:0]         an_nxt;
  logic [7:0]         seg_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex value.
  function automatic logic [6:0] glyph(input logic [3:0] val);
    logic [6:0] g;
    case (val)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Slot timer and digit index; idx advances only when the slot timer wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Free-running blink timer, unrelated to the scan timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Digit buffer: every strobe is accepted, one entry per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        dbuf[i] <= ENTRY_DARK;
      end
    end else if (wr_en) begin
      dbuf[wr_addr] <= {wr_blank, wr_dp, wr_data};
    end
  end

  // Next anode/segment values from this cycle's scan, buffer and blink state.
  always_comb begin
    ent     = dbuf[idx];
    an_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (scan_cnt >= BLANK_END) begin
      an_nxt = ~(8'h01 << idx);
      if (!(blink_phase && blink_mask[idx]) && !ent[5]) begin
        seg_nxt = {~ent[4], glyph(ent[3:0])};
      end
    end
  end

  // Output register: one cycle of latency, dark while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_an  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      seg_an  <= an_nxt;
      seg_out <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a short scan (4-cycle slots,
// 1 dead cycle) and a 16-cycle blink half-period.
module tb_seg_scan_display;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BD = 16;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic [7:0] blink_mask;
  logic [7:0] seg_an;
  logic [7:0] seg_out;

  int checks;
  int errors;
  int cyc;

  logic [3:0] m_val [8];
  logic       m_dp  [8];
  logic       m_blk [8];

  seg_scan_display #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC),
    .BLINK_DIV(BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .wr_blank  (wr_blank),
    .blink_mask(blink_mask),
    .seg_an    (seg_an),
    .seg_out   (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Output seen after release edge c reflects state just before edge c.
  function automatic int pos_of(input int c);
    return (c - 1) % SD;
  endfunction

  function automatic int idx_of(input int c);
    return ((c - 1) / SD) % 8;
  endfunction

  function automatic logic phase_of(input int c);
    return (((c - 1) / BD) % 2) == 1;
  endfunction

  function automatic logic [7:0] exp_an(input int c);
    logic [7:0] one;
    one = 8'h01;
    if (pos_of(c) < BC) return 8'hFF;
    return ~(one << idx_of(c));
  endfunction

  function automatic logic [7:0] exp_seg(input int c);
    int i;
    i = idx_of(c);
    if (pos_of(c) < BC) return 8'hFF;
    if (phase_of(c) && blink_mask[i]) return 8'hFF;
    if (m_blk[i]) return 8'hFF;
    return {~m_dp[i], ref_glyph(m_val[i])};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_val[i] = 4'h0;
      m_dp[i]  = 1'b0;
      m_blk[i] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_cycle(input string tag);
    chk({tag, "_an"}, seg_an, exp_an(cyc));
    chk({tag, "_seg"}, seg_out, exp_seg(cyc));
  endtask

  task automatic wr(input int a, input logic [3:0] v, input logic d, input logic b);
    wr_en    = 1'b1;
    wr_addr  = 3'(a);
    wr_data  = v;
    wr_dp    = d;
    wr_blank = b;
    step();
    wr_en    = 1'b0;
    m_val[a] = v;
    m_dp[a]  = d;
    m_blk[a] = b;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst        = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = 4'h0;
    wr_dp      = 1'b0;
    wr_blank   = 1'b0;
    blink_mask = 8'h00;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_seg", seg_out, 8'hFF);
    rst = 1'b1;
    cyc = 0;

    // Idle scan with an empty buffer: anodes cycle, segments stay dark
    step();
    chk("first_slot_an", seg_an, 8'hFF);
    step();
    chk("first_lit_an", seg_an, 8'hFE);
    chk("first_lit_seg", seg_out, 8'hFF);
    repeat (38) begin
      step();
      chk_cycle("idle");
    end

    // Glyphs 0..7 across all digits, then 8..F
    for (int i = 0; i < 8; i++) wr(i, 4'(i), 1'b0, 1'b0);
    repeat (34) begin
      step();
      chk_cycle("scan_lo");
    end
    for (int i = 0; i < 8; i++) wr(i, 4'(i + 8), 1'b0, 1'b0);
    repeat (34) begin
      step();
      chk_cycle("scan_hi");
    end

    // Decimal point then blank on digit 2
    wr(2, 4'h5, 1'b1, 1'b0);
    for (int n = 0; n < 64 && !(pos_of(cyc) == 1 && idx_of(cyc) == 2); n++) begin
      step();
      chk_cycle("dp_wait");
    end
    chk("dp_an", seg_an, 8'hFB);
    chk("dp_glyph", seg_out, 8'h12);
    wr(2, 4'h5, 1'b1, 1'b1);
    chk("blank_1cyc", seg_out, 8'h12);
    step();
    chk("blank_2cyc", seg_out, 8'hFF);
    chk("blank_an", seg_an, 8'hFB);

    // Blink: digit 0 always lands in phase 0, digit 5 always in phase 1
    wr(0, 4'h8, 1'b0, 1'b0);
    wr(5, 4'h8, 1'b0, 1'b0);
    blink_mask = 8'h21;
    repeat (64) begin
      step();
      chk_cycle("blink");
    end
    for (int n = 0; n < 64 && !(pos_of(cyc) == 1 && idx_of(cyc) == 0); n++) step();
    chk("blink_d0", seg_out, 8'h80);
    for (int n = 0; n < 64 && !(pos_of(cyc) == 1 && idx_of(cyc) == 5); n++) step();
    chk("blink_d5_an", seg_an, 8'hDF);
    chk("blink_d5", seg_out, 8'hFF);
    blink_mask = 8'h00;
    repeat (32) begin
      step();
      chk_cycle("noblink");
    end

    // Write to digit 1 on the same edge idx moves 0 -> 1
    for (int n = 0; n < 64 && !((cyc % SD) == SD - 1 && ((cyc / SD) % 8) == 0); n++) begin
      step();
      chk_cycle("haz_wait");
    end
    wr(1, 4'hA, 1'b0, 1'b0);
    chk_cycle("haz_edge");
    step();
    chk("haz_dead_an", seg_an, 8'hFF);
    step();
    chk("haz_an", seg_an, 8'hFD);
    chk("haz_seg", seg_out, 8'h88);

    // Asynchronous reset in the middle of slot 5
    for (int n = 0; n < 64 && !(pos_of(cyc) == 2 && idx_of(cyc) == 5); n++) begin
      step();
      chk_cycle("ar_wait");
    end
    chk("ar_pre_an", seg_an, 8'hDF);
    #2 rst = 1'b0;
    #1;
    chk("ar_an", seg_an, 8'hFF);
    chk("ar_seg", seg_out, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    model_clear();
    step();
    chk("ar_rel_an0", seg_an, 8'hFF);
    step();
    chk("ar_rel_an1", seg_an, 8'hFE);
    chk("ar_rel_seg", seg_out, 8'hFF);
    repeat (36) begin
      step();
      chk_cycle("ar_scan");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
